uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit framer; sits directly downstream of the baud generator.
//  Accepts a parallel word on a valid/ready handshake and shifts it out LSB-first:
//  start bit, optional parity, 1-2 stop bits. Each rising edge of baud_clk marks one bit period.
//  baud_clk is generated from clk, so no synchronizer is needed.
// PARAMETERS
//  DATA_BITS   8  payload width, legal 5..8
//  PARITY_EN   0  1 = append parity bit after data
//  PARITY_ODD  0  0 = even parity, 1 = odd (ignored if PARITY_EN=0)
//  STOP_BITS   1  stop bit count, legal 1 or 2
// PORTS
//  clk       in   1          system clock, all logic on posedge
//  resetn    in   1          asynchronous, active-low reset
//  baud_clk  in   1          toggling baud clock from generator; one rising edge = one bit period
//  tx_data   in   DATA_BITS  word to send, sampled on accept
//  tx_valid  in   1          upstream has a word
//  tx_ready  out  1          block can accept; accept = tx_valid & tx_ready at posedge clk
//  tx        out  1          serial line, idle high
//  tx_busy   out  1          frame in progress
//  tx_done   out  1          one-clk pulse when the last stop bit completes
// BEHAVIOUR
//  Reset (async, while resetn=0): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud_q=0.
//  Strobe: baud_q <= baud_clk each clk; strb = baud_clk & ~baud_q (one clk wide).
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   tx=1, tx_ready=1. On accept: latch tx_data into shift reg, compute parity,
//           bit_cnt=0, go to START. tx_ready=0 and tx_busy=1 from the next clk.
//   START:  wait for strb. At strb: tx<=0, go to DATA. A strb in the accept cycle itself is not used.
//   DATA:   at each strb: tx<=shreg[0], shift right, bit_cnt++. After DATA_BITS strobes go to
//           PARITY if PARITY_EN, else to STOP.
//   PARITY: tx holds last data bit until strb. At strb: tx <= ^data ^ PARITY_ODD. Go to STOP.
//   STOP:   at strb: tx<=1, then count STOP_BITS further strobes. On the final one:
//           tx_done=1 for 1 clk, tx_busy=0, tx_ready=1, go to IDLE.
//  Each bit lasts exactly one baud_clk period, i.e. from strb to next strb.
//  Frame = 1 + DATA_BITS + PARITY_EN + STOP_BITS periods after the first post-accept strb.
//  Back-to-back: tx_ready is high in the tx_done cycle. An accept there starts the next frame;
//  its start bit lands on the next strb, so there is no idle gap beyond the stop bits.
//  tx_valid while busy: ignored, no latch; upstream must hold the word.
//  tx_data changes after accept do not affect the frame in flight.
//  Reset mid-frame: tx returns to 1 immediately (async); the frame is dropped.
//  After release the FSM is in IDLE with no partial frame.
//  bit_cnt width is $clog2(DATA_BITS+1); it saturates at no value and is cleared on accept.
// STRUCTURE
//  Package uart_pkg: tx_state_t enum {IDLE,START,DATA,PARITY,STOP};
//   baud select constants BAUD48=0, BAUD96=1, BAUD192=2, BAUD384=3 (shared with the baud generator);
//   function parity_f(data, odd).
//  One sub-module: uart_bit_strobe (baud_clk edge detector producing strb).
//  FSM, shift register and counters stay inline.
// TESTING
//  1 Reset, hold resetn=0 for 5 clk -> tx=1, tx_ready=1, tx_busy=0, tx_done=0.
//  2 8N1, send 0xA5, baud_rate=3 (940 clk/bit) -> tx = 0,1,0,1,0,0,1,0,1,1,
//    each bit 940 clk; tx_done once.
//  3 PARITY_EN=1: send 0x07 even -> parity bit 1; PARITY_ODD=1 -> parity bit 0;
//    STOP_BITS=2 -> stop lasts 2 bit periods.
//  4 Back-to-back 0x55 then 0xAA with tx_valid held -> stop of frame 1 is followed immediately
//    by the start of frame 2; tx_ready high only in the tx_done cycle.
//  5 resetn pulsed low during data bit 3 of 0xF0 -> tx=1 the same cycle.
//    After release, 0x3C is sent cleanly with a correct frame.
//  6 Toggle tx_data and pulse tx_valid while busy -> in-flight frame unchanged;
//    no extra frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud-select codes used
// by the baud generator, and the parity helper.
package uart_pkg;

  // Widest payload the transmitter supports; parity helper is sized for it.
  localparam int unsigned MAX_DATA_BITS = 8;

  // Baud select codes understood by the baud generator.
  localparam logic [1:0] BAUD48  = 2'd0;
  localparam logic [1:0] BAUD96  = 2'd1;
  localparam logic [1:0] BAUD192 = 2'd2;
  localparam logic [1:0] BAUD384 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity of the payload, inverted when odd parity is selected.
  // Unused upper bits must be zero so they do not disturb the result.
  function automatic logic parity_f(input logic [MAX_DATA_BITS-1:0] data,
                                    input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_strobe.sv
// Turns the free-running baud clock into a one-clk strobe on each of its
// rising edges. baud_clk is derived from clk, so it is sampled directly.
module uart_bit_strobe (
  input  logic clk,
  input  logic resetn,
  input  logic baud_clk,
  output logic strb
);

  logic baud_q;

  // Delay the baud clock by one clk so its rising edge can be detected.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: flops are written with <= so every reader sees the pre-edge value.
    if (!resetn) baud_q <= 1'b0;
    else         baud_q <= baud_clk;
  end

  assign strb = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit framer: accepts a word on a valid/ready handshake and shifts it
// out LSB-first as start bit, data bits, optional parity, then stop bit(s).
// Every line transition happens on a baud strobe, so each bit lasts one period.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS);

  tx_state_t                state;
  logic [DATA_BITS-1:0]     shreg;
  logic                     parity_q;
  logic [CNT_W-1:0]         bit_cnt;
  logic [1:0]               stop_cnt;
  logic                     strb;
  logic [MAX_DATA_BITS-1:0] data_ext;

  uart_bit_strobe u_bit_strobe (
    .clk      (clk),
    .resetn   (resetn),
    .baud_clk (baud_clk),
    .strb     (strb)
  );

  // Zero-extend the payload so the parity helper sees a fixed width.
  always_comb begin
    data_ext                = '0;
    data_ext[DATA_BITS-1:0] = tx_data;
  end

  // Frame sequencer: handshake, shift register, bit/stop counters and the
  // registered line outputs all advance together on baud strobes.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the async reset puts the line idle-high at once; the shift register
    // is reset too, so no stale payload survives into the next frame.
    if (!resetn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shreg    <= '0;
      parity_q <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // A strobe coinciding with the accept is deliberately not used.
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            parity_q <= parity_f(data_ext, PARITY_ODD != 0);
            bit_cnt  <= '0;
            stop_cnt <= '0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (strb) begin
            tx    <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (strb) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_DATA) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (strb) begin
            tx    <= parity_q;
            state <= STOP;
          end
        end
        STOP: begin
          // First strobe raises the line; STOP_BITS further strobes end the frame.
          if (strb) begin
            if (stop_cnt == 2'd0) tx <= 1'b1;
            if (stop_cnt == LAST_STOP) begin
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
